// File: rtl/square_wave_rom_sched.sv
`default_nettype none
// ============================================================================
//  Module   : square_wave_rom_sched
//  Purpose  : Two-channel DDS scheduler that time-shares one single-port
//             square-wave ROM and returns each read sample to its own channel.
//  Revision : 1.0
// ============================================================================
module square_wave_rom_sched #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int PHASE_WIDTH = 32,
    parameter int ROM_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic                   cfg_ch,
    input  logic [PHASE_WIDTH-1:0] cfg_fword,
    input  logic [ADDR_WIDTH-1:0]  cfg_poff,
    input  logic                   cfg_clr,
    input  logic [1:0]             ch_en,
    output logic [ADDR_WIDTH-1:0]  rom_addr,
    output logic                   rom_clk_en,
    input  logic [DATA_WIDTH-1:0]  rom_rd_data,
    output logic [DATA_WIDTH-1:0]  ch0_data,
    output logic                   ch0_valid,
    output logic [DATA_WIDTH-1:0]  ch1_data,
    output logic                   ch1_valid
);

    localparam int c_NUM_CH = 2;

    logic [PHASE_WIDTH-1:0] r_acc   [c_NUM_CH];
    logic [PHASE_WIDTH-1:0] r_fword [c_NUM_CH];
    logic [ADDR_WIDTH-1:0]  r_poff  [c_NUM_CH];

    logic                   r_slot;
    logic                   r_cfg_ready;
    logic [ADDR_WIDTH-1:0]  r_rom_addr;
    logic                   r_rom_clk_en;
    logic [ROM_LATENCY:0]   r_tag_vld;
    logic [ROM_LATENCY:0]   r_tag_ch;
    logic [DATA_WIDTH-1:0]  r_ch0_data;
    logic [DATA_WIDTH-1:0]  r_ch1_data;
    logic                   r_ch0_valid;
    logic                   r_ch1_valid;

    logic                   w_issue;
    logic                   w_cfg_xfer;
    logic [PHASE_WIDTH-1:0] w_acc_sel;
    logic [ADDR_WIDTH-1:0]  w_issue_addr;
    logic                   w_ret_vld;
    logic                   w_ret_ch;

    assign w_issue      = ch_en[r_slot];
    assign w_cfg_xfer   = cfg_valid & r_cfg_ready;
    assign w_acc_sel    = r_acc[r_slot];
    assign w_issue_addr = w_acc_sel[PHASE_WIDTH-1 -: ADDR_WIDTH] + r_poff[r_slot];
    assign w_ret_vld    = r_tag_vld[ROM_LATENCY];
    assign w_ret_ch     = r_tag_ch[ROM_LATENCY];

    // Slot owner alternates every cycle; config is throttled to one accept per two cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_slot      <= ~r_slot;
            r_cfg_ready <= ~w_cfg_xfer;
        end
    end

    // Issue in the same cycle as a config accept still sees the old state; clear beats increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < c_NUM_CH; c++) begin
                r_acc[c]   <= '0;
                r_fword[c] <= '0;
                r_poff[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < c_NUM_CH; c++) begin
                if (w_cfg_xfer && (cfg_ch == c[0])) begin
                    r_fword[c] <= cfg_fword;
                    r_poff[c]  <= cfg_poff;
                end
                if (w_cfg_xfer && (cfg_ch == c[0]) && cfg_clr) begin
                    r_acc[c] <= '0;
                end else if (w_issue && (r_slot == c[0])) begin
                    r_acc[c] <= r_acc[c] + r_fword[c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr   <= '0;
            r_rom_clk_en <= 1'b0;
            r_tag_vld    <= '0;
            r_tag_ch     <= '0;
        end else begin
            r_rom_clk_en <= w_issue;
            if (w_issue) begin
                r_rom_addr <= w_issue_addr;
            end
            r_tag_vld <= {r_tag_vld[ROM_LATENCY-1:0], w_issue};
            r_tag_ch  <= {r_tag_ch[ROM_LATENCY-1:0], r_slot};
        end
    end

    // Tag's last stage lines up with the cycle rom_rd_data carries that read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch0_data  <= '0;
            r_ch1_data  <= '0;
            r_ch0_valid <= 1'b0;
            r_ch1_valid <= 1'b0;
        end else begin
            r_ch0_valid <= w_ret_vld & ~w_ret_ch;
            r_ch1_valid <= w_ret_vld & w_ret_ch;
            if (w_ret_vld && !w_ret_ch) begin
                r_ch0_data <= rom_rd_data;
            end
            if (w_ret_vld && w_ret_ch) begin
                r_ch1_data <= rom_rd_data;
            end
        end
    end

    assign cfg_ready  = r_cfg_ready;
    assign rom_addr   = r_rom_addr;
    assign rom_clk_en = r_rom_clk_en;
    assign ch0_data   = r_ch0_data;
    assign ch0_valid  = r_ch0_valid;
    assign ch1_data   = r_ch1_data;
    assign ch1_valid  = r_ch1_valid;

endmodule
`default_nettype wire

// File: tb/tb_square_wave_rom_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_square_wave_rom_sched
//  Purpose  : Directed bench driving a ROM_LATENCY=1 and a ROM_LATENCY=2
//             instance side by side, each with an address-echo ROM model.
//  Revision : 1.0
// ============================================================================
module tb_square_wave_rom_sched;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int PW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cfg_valid;
    logic          cfg_ch;
    logic [PW-1:0] cfg_fword;
    logic [AW-1:0] cfg_poff;
    logic          cfg_clr;
    logic [1:0]    ch_en;

    // Index 0: ROM_LATENCY=1 instance, index 1: ROM_LATENCY=2 instance
    logic [1:0]         ready_o;
    logic [1:0][AW-1:0] addr_o;
    logic [1:0]         en_o;
    logic [1:0][DW-1:0] rd_i;
    logic [1:0][DW-1:0] d0_o;
    logic [1:0][DW-1:0] d1_o;
    logic [1:0]         v0_o;
    logic [1:0]         v1_o;

    square_wave_rom_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ROM_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(ready_o[0]), .cfg_ch(cfg_ch),
        .cfg_fword(cfg_fword), .cfg_poff(cfg_poff), .cfg_clr(cfg_clr), .ch_en(ch_en),
        .rom_addr(addr_o[0]), .rom_clk_en(en_o[0]), .rom_rd_data(rd_i[0]),
        .ch0_data(d0_o[0]), .ch0_valid(v0_o[0]), .ch1_data(d1_o[0]), .ch1_valid(v1_o[0])
    );

    square_wave_rom_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ROM_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(ready_o[1]), .cfg_ch(cfg_ch),
        .cfg_fword(cfg_fword), .cfg_poff(cfg_poff), .cfg_clr(cfg_clr), .ch_en(ch_en),
        .rom_addr(addr_o[1]), .rom_clk_en(en_o[1]), .rom_rd_data(rd_i[1]),
        .ch0_data(d0_o[1]), .ch0_valid(v0_o[1]), .ch1_data(d1_o[1]), .ch1_valid(v1_o[1])
    );

    // ROM models: data = address
    logic [AW-1:0] q1 = '0;
    logic [AW-1:0] q2a = '0;
    logic [AW-1:0] q2b = '0;
    always @(posedge clk) begin
        if (en_o[0]) q1 <= addr_o[0];
        if (en_o[1]) q2a <= addr_o[1];
        q2b <= q2a;
    end
    assign rd_i[0] = {{(DW-AW){1'b0}}, q1};
    assign rd_i[1] = {{(DW-AW){1'b0}}, q2b};

    typedef struct packed {
        logic          en;
        logic          ch;
        logic [AW-1:0] addr;
    } iss_t;

    typedef struct {
        logic [1:0]    en_in;
        logic          x_en;
        logic [AW-1:0] x_addr;
    } vec_t;

    iss_t          p [0:3];
    logic [DW-1:0] ed [2][2];
    vec_t          tbl [$];
    int            ecnt;
    int            n_chk;
    int            n_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 4; k++) p[k] = '0;
        for (int d = 0; d < 2; d++) begin
            ed[d][0] = '0;
            ed[d][1] = '0;
        end
        ecnt = 0;
    endtask

    task automatic chk_ready(input logic exp);
        chk("cfg_ready_l1", 32'(ready_o[0]), 32'(exp));
        chk("cfg_ready_l2", 32'(ready_o[1]), 32'(exp));
    endtask

    // One clock: record the expected issue of this slot, check ROM side and returns
    task automatic tick(input logic x_en, input logic [AW-1:0] x_addr);
        iss_t r;
        logic xv0, xv1;
        @(posedge clk);
        #1;
        for (int k = 3; k > 0; k--) p[k] = p[k-1];
        p[0] = '{en: x_en, ch: ecnt[0], addr: x_addr};
        ecnt++;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rom_clk_en_l%0d e%0d", d+1, ecnt-1), 32'(en_o[d]), 32'(x_en));
            chk($sformatf("rom_addr_l%0d e%0d", d+1, ecnt-1), 32'(addr_o[d]), 32'(x_addr));
            r   = p[d+2];
            xv0 = r.en & ~r.ch;
            xv1 = r.en & r.ch;
            if (xv0) ed[d][0] = {{(DW-AW){1'b0}}, r.addr};
            if (xv1) ed[d][1] = {{(DW-AW){1'b0}}, r.addr};
            chk($sformatf("ch0_valid_l%0d e%0d", d+1, ecnt-1), 32'(v0_o[d]), 32'(xv0));
            chk($sformatf("ch1_valid_l%0d e%0d", d+1, ecnt-1), 32'(v1_o[d]), 32'(xv1));
            chk($sformatf("ch0_data_l%0d e%0d", d+1, ecnt-1), d0_o[d], ed[d][0]);
            chk($sformatf("ch1_data_l%0d e%0d", d+1, ecnt-1), d1_o[d], ed[d][1]);
        end
    endtask

    task automatic add(input logic [1:0] en_in, input logic x_en, input int x_addr);
        vec_t v;
        v.en_in  = en_in;
        v.x_en   = x_en;
        v.x_addr = x_addr[AW-1:0];
        tbl.push_back(v);
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) begin
            ch_en = tbl[i].en_in;
            tick(tbl[i].x_en, tbl[i].x_addr);
        end
        tbl.delete();
    endtask

    task automatic set_cfg(input logic ch, input logic [PW-1:0] fw, input logic [AW-1:0] po, input logic clr);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_fword = fw;
        cfg_poff  = po;
        cfg_clr   = clr;
    endtask

    task automatic chk_reset_state(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s rom_addr_l%0d", tag, d+1), 32'(addr_o[d]), 32'd0);
            chk($sformatf("%s rom_clk_en_l%0d", tag, d+1), 32'(en_o[d]), 32'd0);
            chk($sformatf("%s ch0_valid_l%0d", tag, d+1), 32'(v0_o[d]), 32'd0);
            chk($sformatf("%s ch1_valid_l%0d", tag, d+1), 32'(v1_o[d]), 32'd0);
            chk($sformatf("%s ch0_data_l%0d", tag, d+1), d0_o[d], 32'd0);
            chk($sformatf("%s ch1_data_l%0d", tag, d+1), d1_o[d], 32'd0);
            chk($sformatf("%s cfg_ready_l%0d", tag, d+1), 32'(ready_o[d]), 32'd1);
        end
    endtask

    initial begin
        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_fword = '0;
        cfg_poff  = '0;
        cfg_clr   = 1'b0;
        ch_en     = 2'b00;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("in_reset");
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, '0);
            chk_ready(1'b1);
        end

        // ch0 step +1
        set_cfg(1'b0, 32'h0040_0000, 10'd0, 1'b0);
        tick(1'b0, '0);
        cfg_valid = 1'b0;
        chk_ready(1'b0);
        tick(1'b0, '0);
        chk_ready(1'b1);
        for (int a = 0; a < 6; a++) begin
            add(2'b01, 1'b1, a);
            add(2'b01, 1'b0, a);
        end
        for (int i = 0; i < 3; i++) add(2'b00, 1'b0, 5);
        run_tbl();

        // Upward wrap with poff 1021
        set_cfg(1'b0, 32'h0040_0000, 10'd1021, 1'b1);
        tick(1'b0, 10'd5);
        cfg_valid = 1'b0;
        chk_ready(1'b0);
        tick(1'b0, 10'd5);
        chk_ready(1'b1);
        tick(1'b0, 10'd5);
        add(2'b01, 1'b1, 1021); add(2'b01, 1'b0, 1021);
        add(2'b01, 1'b1, 1022); add(2'b01, 1'b0, 1022);
        add(2'b01, 1'b1, 1023); add(2'b01, 1'b0, 1023);
        add(2'b01, 1'b1, 0);    add(2'b01, 1'b0, 0);
        add(2'b01, 1'b1, 1);    add(2'b01, 1'b0, 1);
        add(2'b01, 1'b1, 2);
        run_tbl();

        // Step -1 from 0, configured in ch1's slot while ch0 runs
        set_cfg(1'b0, 32'hFFC0_0000, 10'd0, 1'b1);
        tick(1'b0, 10'd2);
        cfg_valid = 1'b0;
        chk_ready(1'b0);
        add(2'b01, 1'b1, 0);    add(2'b01, 1'b0, 0);
        add(2'b01, 1'b1, 1023); add(2'b01, 1'b0, 1023);
        add(2'b01, 1'b1, 1022); add(2'b01, 1'b0, 1022);
        add(2'b01, 1'b1, 1021);
        for (int i = 0; i < 3; i++) add(2'b00, 1'b0, 1021);
        run_tbl();

        // Back-to-back cfg_valid: second transfer lands two cycles after the first
        set_cfg(1'b0, 32'h0040_0000, 10'd0, 1'b1);
        tick(1'b0, 10'd1021);
        chk_ready(1'b0);
        set_cfg(1'b0, 32'hDEAD_BEEF, 10'd77, 1'b0);
        tick(1'b0, 10'd1021);
        chk_ready(1'b1);
        set_cfg(1'b1, 32'h0080_0000, 10'd512, 1'b1);
        tick(1'b0, 10'd1021);
        cfg_valid = 1'b0;
        chk_ready(1'b0);
        tick(1'b0, 10'd1021);
        chk_ready(1'b1);

        // Both channels interleaved
        for (int k = 0; k < 5; k++) begin
            add(2'b11, 1'b1, k);
            add(2'b11, 1'b1, 512 + 2*k);
        end
        for (int i = 0; i < 3; i++) add(2'b00, 1'b0, 520);
        run_tbl();

        // Collision with clear: issue uses old state, next ch0 address = new poff
        ch_en = 2'b01;
        tick(1'b0, 10'd520);
        set_cfg(1'b0, 32'h0040_0000, 10'd100, 1'b1);
        tick(1'b1, 10'd5);
        cfg_valid = 1'b0;
        chk_ready(1'b0);
        tick(1'b0, 10'd5);
        tick(1'b1, 10'd100);
        tick(1'b0, 10'd100);
        // Collision without clear: old poff/fword for this issue, old acc+old fword after
        set_cfg(1'b0, 32'h0080_0000, 10'd200, 1'b0);
        tick(1'b1, 10'd101);
        cfg_valid = 1'b0;
        add(2'b01, 1'b0, 101);
        add(2'b01, 1'b1, 202); add(2'b01, 1'b0, 202);
        add(2'b01, 1'b1, 204);
        for (int i = 0; i < 3; i++) add(2'b00, 1'b0, 204);
        // ch1 accumulator untouched by ch0 configs
        add(2'b10, 1'b0, 204);
        add(2'b10, 1'b1, 522);
        // Two reads in flight before reset
        add(2'b11, 1'b1, 206);
        add(2'b11, 1'b1, 524);
        run_tbl();

        rst_n = 1'b0;
        ch_en = 2'b00;
        #1;
        chk_reset_state("async_reset");
        @(posedge clk);
        #1;
        chk_reset_state("reset_held");
        rst_n = 1'b1;
        clear_model();
        for (int i = 0; i < 4; i++) add(2'b00, 1'b0, 0);
        add(2'b01, 1'b1, 0); add(2'b01, 1'b0, 0);
        add(2'b01, 1'b1, 0);
        for (int i = 0; i < 3; i++) add(2'b00, 1'b0, 0);
        run_tbl();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/square_wave_rom_sched.md
Name: square_wave_rom_sched

Overview:
- Time-multiplexed DDS scheduler that shares one single-port square-wave ROM between two waveform channels.
- Each channel has its own phase accumulator, frequency word and phase offset.
- Alternate clock slots belong to alternate channels. Each slot issues at most one ROM read, then routes the returned sample to the owning channel's output with a valid strobe.
- Sits between the register/config logic and the ROM instance. Drives the ROM's addr/clk_en and consumes its rd_data.

Parameters:
- ADDR_WIDTH, 10, ROM address width; equals ROM depth log2.
- DATA_WIDTH, 32, ROM data width.
- PHASE_WIDTH, 32, accumulator width; must be >= ADDR_WIDTH.
- ROM_LATENCY, 1, ROM read latency in cycles: 1 = no ROM output register, 2 = ROM output register enabled.

Ports:
- clk  input  1  system clock; also clocks the ROM.
- rst_n  input  1  asynchronous active-low reset.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config can be accepted.
- cfg_ch  input  1  target channel (0/1).
- cfg_fword  input  PHASE_WIDTH  frequency (phase increment) word.
- cfg_poff  input  ADDR_WIDTH  phase offset added to the ROM address.
- cfg_clr  input  1  clear the target accumulator on accept.
- ch_en  input  2  per-channel run enable.
- rom_addr  output  ADDR_WIDTH  ROM address (registered).
- rom_clk_en  output  1  ROM read strobe (registered).
- rom_rd_data  input  DATA_WIDTH  ROM read data.
- ch0_data  output  DATA_WIDTH  channel 0 sample.
- ch0_valid  output  1  one-cycle strobe; ch0_data is new.
- ch1_data  output  DATA_WIDTH  channel 1 sample.
- ch1_valid  output  1  one-cycle strobe; ch1_data is new.

Behaviour:

Reset (async assert, release on clk):
- Slot toggle = 0.
- Accumulators, fwords, poffs = 0.
- In-flight tag pipeline cleared.
- rom_addr = 0, rom_clk_en = 0.
- chX_data = 0, chX_valid = 0, cfg_ready = 1.

Slot schedule:
- Slot bit toggles every cycle after reset: cycle 0 = ch0, cycle 1 = ch1, and so on.
- In a slot owned by channel c with ch_en[c] = 1:
  - register rom_addr = acc_c[PHASE_WIDTH-1 -: ADDR_WIDTH] + poff_c, mod 2^ADDR_WIDTH (natural wrap, no saturation).
  - register rom_clk_en = 1.
  - acc_c <= acc_c + fword_c, mod 2^PHASE_WIDTH.
- In a slot where ch_en[c] = 0: rom_clk_en = 0, rom_addr holds, acc_c holds.

Read return:
- A tag pipeline of ROM_LATENCY+1 stages carries {valid, ch}.
- Read issued with rom_addr/rom_clk_en presented in cycle N → rom_rd_data valid in cycle N+ROM_LATENCY → captured into ch<tag>_data with ch<tag>_valid = 1 in cycle N+ROM_LATENCY+1, for exactly one cycle.
- Each enabled channel therefore produces one sample every 2 cycles.
- chX_data holds its value between strobes.

Disable and enable:
- Deasserting ch_en[c] stops new issues only. Reads already in flight still complete and strobe.
- Re-enable resumes from the held accumulator at the channel's next slot.

Config handshake:
- Transfer occurs when cfg_valid & cfg_ready.
- cfg_ready drops for the one cycle after each accept, so at most one accept per 2 cycles.
- On accept: fword_cfg_ch <= cfg_fword, poff_cfg_ch <= cfg_poff.
- If cfg_clr = 1: acc_cfg_ch <= 0.
- New values are used from the channel's first slot strictly after the accept cycle.

Collision (accept in the same cycle as the target channel's slot):
- The issue uses the old acc/fword/poff.
- The accumulator update then resolves as: cfg_clr = 1 → acc <= 0 (clear wins over increment); cfg_clr = 0 → acc <= old acc + old fword.

Other:
- The idle channel's accumulator is never modified by the other channel's config.
- Reset asserted mid-operation: all outputs return to reset values immediately. No valid strobe from a pre-reset read ever appears after release.

Test Plan:
1. Reset, then hold 10 cycles with ch_en = 0 → rom_clk_en = 0, ch0_valid = ch1_valid = 0, cfg_ready = 1, rom_addr = 0 throughout.
2. Config ch0 with fword = 0x00400000 (step 1), poff = 0; ch_en = 01; ROM model returns data = addr.
   - rom_addr = 0, 1, 2, … on every second cycle.
   - ch0_valid pulses every 2 cycles, with ch0_data following addr at ROM_LATENCY+1 latency.
   - ch1_valid stays 0.
   - Repeat with ROM_LATENCY = 2.
3. Wrap: ch0 fword = 0x00400000, poff = 1021 → addresses 1021, 1022, 1023, 0, 1.
   - Then fword = 0xFFC00000 (step −1) → addresses decrement through 0 to 1023.
4. Both channels: ch1 fword = 0x00800000, poff = 512; ch_en = 11.
   - rom_clk_en = 1 every cycle.
   - Addresses interleave ch0: 0, 1, 2… and ch1: 512, 514, 516….
   - ch0_valid and ch1_valid alternate, never coincide.
5. Config collision: accept cfg_clr = 1 for ch0 in ch0's slot → that slot uses the old address; the next ch0 address = poff.
   - Back-to-back cfg_valid → cfg_ready low the cycle after each accept; the second transfer completes 2 cycles after the first.
6. With 2 reads in flight, pulse rst_n low for 1 cycle → all outputs are 0 during reset; no ch0_valid/ch1_valid before a new issue after release.
